voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_pkg.sv | 20 ++
 rtl/voice_age_tracker.sv | 50 +++++
 rtl/voice_allocator.sv | 170 +++++++++++++++++
 tb/tb_voice_allocator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared types and defaults for the voice allocator and its age tracker.
package voice_pkg;

  localparam int DEF_VOICES = 8;
  localparam int DEF_AGE_W  = 8;

  typedef logic [8:0] key_id_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    key_id_t id;
    logic    pressed;
  } voice_event_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; reports the oldest gated voice
// (largest age, lowest index on tie) for voice stealing.
module voice_age_tracker
  import voice_pkg::*;
#(
  parameter int VOICES = DEF_VOICES,
  parameter int AGE_W  = DEF_AGE_W,
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              assign_valid,
  input  logic [IDX_W-1:0]  assign_idx,
  input  logic [VOICES-1:0] gate,
  output logic [IDX_W-1:0]  oldest_idx
);

  logic [AGE_W-1:0] age_q [VOICES];
  logic [AGE_W-1:0] best_age;
  logic             best_vld;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) age_q[i] <= '0;
    end else if (assign_valid) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IDX_W'(i) == assign_idx) begin
          age_q[i] <= '0;
        end else if (gate[i] && (age_q[i] != '1)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    oldest_idx = '0;
    best_age   = '0;
    best_vld   = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      if (gate[i] && (!best_vld || (age_q[i] > best_age))) begin
        oldest_idx = IDX_W'(i);
        best_age   = age_q[i];
        best_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// PS/2 key event to synth voice allocator: IDLE -> SCAN (one voice/cycle) -> COMMIT.
// Define VOICE_STEAL_EN to steal the oldest voice when none is free.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int VOICES = DEF_VOICES,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [10:0]            ps2_key,
  output key_id_t [VOICES-1:0]   voice_key,
  output logic    [VOICES-1:0]   voice_gate,
  output logic    [VOICES-1:0]   voice_trig,
  output logic                   busy,
  output logic    [15:0]         dropped_count,
  output state_t                 dbg_state
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  state_t           state;
  logic             toggle_q;
  logic             pend_valid;
  voice_event_t     pend_ev;
  voice_event_t     cur_ev;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] free_idx;
  logic             match_vld;
  logic             free_vld;
  logic [IDX_W-1:0] oldest_idx;

  logic             ev_strobe;
  logic             take;
  logic             overflow;
  logic             commit_assign;
  logic             commit_release;
  logic             commit_drop;
  logic [IDX_W-1:0] commit_idx;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  assign ev_strobe = ps2_key[10] ^ toggle_q;
  assign take      = (state == ST_IDLE) && pend_valid;
  // The pending slot frees in the same cycle IDLE consumes it.
  assign overflow  = ev_strobe && pend_valid && !take;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    commit_assign  = 1'b0;
    commit_release = 1'b0;
    commit_drop    = 1'b0;
    commit_idx     = match_idx;
    if (state == ST_COMMIT) begin
      if (cur_ev.pressed) begin
        if (match_vld) begin
          commit_assign = 1'b1;
          commit_idx    = match_idx;
        end else if (free_vld) begin
          commit_assign = 1'b1;
          commit_idx    = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          commit_assign = 1'b1;
          commit_idx    = oldest_idx;
`else
          commit_drop   = 1'b1;
`endif
        end
      end else if (match_vld) begin
        commit_release = 1'b1;
      end
    end
  end

  always_comb begin
    drop_sum  = {1'b0, dropped_count} + 17'(overflow) + 17'(commit_drop);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      toggle_q      <= ps2_key[10];
      pend_valid    <= 1'b0;
      pend_ev       <= '0;
      cur_ev        <= '0;
      scan_idx      <= '0;
      match_idx     <= '0;
      free_idx      <= '0;
      match_vld     <= 1'b0;
      free_vld      <= 1'b0;
      voice_key     <= '0;
      voice_gate    <= '0;
      voice_trig    <= '0;
      dropped_count <= '0;
    end else begin
      toggle_q      <= ps2_key[10];
      voice_trig    <= '0;
      dropped_count <= drop_next;

      if (ev_strobe && (!pend_valid || take)) begin
        pend_valid <= 1'b1;
        pend_ev    <= '{id: ps2_key[8:0], pressed: ps2_key[9]};
      end else if (take) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            cur_ev    <= pend_ev;
            scan_idx  <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (voice_gate[scan_idx] && (voice_key[scan_idx] == cur_ev.id) && !match_vld) begin
            match_vld <= 1'b1;
            match_idx <= scan_idx;
          end
          if (!voice_gate[scan_idx] && !free_vld) begin
            free_vld <= 1'b1;
            free_idx <= scan_idx;
          end
          if (scan_idx == IDX_W'(VOICES - 1)) begin
            state <= ST_COMMIT;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          if (commit_assign) begin
            voice_key[commit_idx]  <= cur_ev.id;
            voice_gate[commit_idx] <= 1'b1;
            voice_trig[commit_idx] <= 1'b1;
          end
          if (commit_release) begin
            voice_gate[commit_idx] <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  voice_age_tracker #(
    .VOICES (VOICES),
    .AGE_W  (AGE_W)
  ) u_age (
    .clk          (clk),
    .reset_n      (reset_n),
    .assign_valid (commit_assign),
    .assign_idx   (commit_idx),
    .gate         (voice_gate),
    .oldest_idx   (oldest_idx)
  );

`ifndef VOICE_STEAL_EN
  logic unused_oldest;
  assign unused_oldest = ^oldest_idx;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: reference model feeds an expected
// queue of {voice_gate, voice_trig} popped after every COMMIT.
module tb_voice_allocator;
  import voice_pkg::*;

  localparam int VOICES  = 8;
  localparam int AGE_W   = 8;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic                 clk;
  logic                 reset_n;
  logic [10:0]          ps2_key;
  key_id_t [VOICES-1:0] voice_key;
  logic [VOICES-1:0]    voice_gate;
  logic [VOICES-1:0]    voice_trig;
  logic                 busy;
  logic [15:0]          dropped_count;
  state_t               dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*VOICES-1:0] exp_q[$];

  logic [VOICES-1:0] m_gate;
  logic [8:0]        m_key [VOICES];
  int                m_age [VOICES];
  int                m_drop;

  bit prev_commit;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .voice_key     (voice_key),
    .voice_gate    (voice_gate),
    .voice_trig    (voice_trig),
    .busy          (busy),
    .dropped_count (dropped_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model ----------------
  task automatic model_clear();
    m_gate = '0;
    m_drop = 0;
    for (int i = 0; i < VOICES; i++) begin
      m_key[i] = '0;
      m_age[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_event(input logic [8:0] id, input logic pressed);
    int tgt;
    logic [VOICES-1:0] trig;
    tgt  = -1;
    trig = '0;
    for (int i = 0; i < VOICES; i++)
      if (m_gate[i] && m_key[i] == id && tgt < 0) tgt = i;
    if (pressed) begin
      if (tgt < 0)
        for (int i = 0; i < VOICES; i++)
          if (!m_gate[i] && tgt < 0) tgt = i;
`ifdef VOICE_STEAL_EN
      if (tgt < 0)
        for (int i = 0; i < VOICES; i++)
          if (m_gate[i] && (tgt < 0 || m_age[i] > m_age[tgt])) tgt = i;
`endif
      if (tgt < 0) begin
        m_drop++;
      end else begin
        for (int i = 0; i < VOICES; i++)
          if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_age[tgt]  = 0;
        m_gate[tgt] = 1'b1;
        m_key[tgt]  = id;
        trig[tgt]   = 1'b1;
      end
    end else if (tgt >= 0) begin
      m_gate[tgt] = 1'b0;
    end
    exp_q.push_back({m_gate, trig});
  endtask

  // ---------------- drivers ----------------
  task automatic raw_key(input logic [8:0] id, input logic pressed);
    @(negedge clk);
    ps2_key = {~ps2_key[10], pressed, id};
  endtask

  task automatic send_key(input logic [8:0] id, input logic pressed);
    raw_key(id, pressed);
    model_event(id, pressed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 200);
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      $display("FAIL %s_timeout: busy=%0b outstanding=%0d, required idle with 0 outstanding",
               tag, busy, exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [2*VOICES-1:0] exp;
    if (!reset_n) begin
      prev_commit = 1'b0;
    end else begin
      if (prev_commit) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL commit_unexpected: gate=%h trig=%h with no expected entry",
                   voice_gate, voice_trig);
        end else begin
          exp = exp_q.pop_front();
          if ({voice_gate, voice_trig} !== exp)
            $display("FAIL commit_out: gate/trig=%h/%h, required %h/%h",
                     voice_gate, voice_trig, exp[2*VOICES-1:VOICES], exp[VOICES-1:0]);
          else
            n_pass++;
        end
      end
      prev_commit = (dbg_state == ST_COMMIT);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    ps2_key[10] = ~ps2_key[10];
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_gate !== '0 || voice_trig !== '0) $display("FAIL reset_gate_trig: %h/%h, required 0/0", voice_gate, voice_trig);
    else n_pass++;
    n_checks++;
    if (voice_key !== '0) $display("FAIL reset_keys: %h, required 0", voice_key);
    else n_pass++;
    n_checks++;
    if (dropped_count !== 16'd0 || busy !== 1'b0) $display("FAIL reset_cnt_busy: %0d/%0b, required 0/0", dropped_count, busy);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || dropped_count !== 16'd0) $display("FAIL reset_no_spurious: busy=%0b drop=%0d, required 0/0", busy, dropped_count);
    else n_pass++;
  endtask

  task automatic test_single_press();
    send_key(9'h015, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (voice_gate !== 8'h00) $display("FAIL press_latency_early: gate=%h after 9 edges, required 00", voice_gate);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_gate !== 8'h01 || voice_trig !== 8'h01) $display("FAIL press_edge10: gate/trig=%h/%h, required 01/01", voice_gate, voice_trig);
    else n_pass++;
    n_checks++;
    if (voice_key[0] !== 9'h015) $display("FAIL press_key0: %h, required 015", voice_key[0]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 8'h00) $display("FAIL press_trig_pulse: trig=%h one cycle later, required 00", voice_trig);
    else n_pass++;
    wait_idle("single");
  endtask

  task automatic test_two_and_release();
    send_key(9'h04A, 1'b1);
    wait_idle("second_press");
    n_checks++;
    if (voice_gate !== 8'h03 || voice_key[1] !== 9'h04A) $display("FAIL two_press: gate=%h key1=%h, required 03/04a", voice_gate, voice_key[1]);
    else n_pass++;
    send_key(9'h015, 1'b0);
    wait_idle("release");
    n_checks++;
    if (voice_gate !== 8'h02 || voice_key[0] !== 9'h015) $display("FAIL release: gate=%h key0=%h, required 02/015", voice_gate, voice_key[0]);
    else n_pass++;
    send_key(9'h077, 1'b0);
    wait_idle("release_nomatch");
    n_checks++;
    if (voice_gate !== 8'h02 || dropped_count !== 16'd0) $display("FAIL release_nomatch: gate=%h drop=%0d, required 02/0", voice_gate, dropped_count);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    send_key(9'h015, 1'b1);
    wait_idle("repress");
    send_key(9'h015, 1'b1);
    wait_idle("retrigger");
    n_checks++;
    if (voice_gate !== 8'h03) $display("FAIL retrig_gate: %h, required 03", voice_gate);
    else n_pass++;
    n_checks++;
    if (dut.u_age.age_q[0] !== AGE_W'(0) || dut.u_age.age_q[1] !== AGE_W'(m_age[1]))
      $display("FAIL retrig_age: age0=%0d age1=%0d, required 0/%0d", dut.u_age.age_q[0], dut.u_age.age_q[1], m_age[1]);
    else n_pass++;
  endtask

  task automatic test_steal();
    logic [8:0] ids [9];
    logic [8:0] want_k0;
    int         want_drop;
    ids = '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034, 9'h033, 9'h03B, 9'h042, 9'h04B};
`ifdef VOICE_STEAL_EN
    want_k0 = 9'h04B; want_drop = 0;
`else
    want_k0 = 9'h01C; want_drop = 1;
`endif
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_key(ids[i], 1'b1);
      wait_idle("steal_fill");
    end
    n_checks++;
    if (voice_key[0] !== want_k0 || voice_key[0] !== m_key[0]) $display("FAIL steal_key0: %h, required %h", voice_key[0], want_k0);
    else n_pass++;
    n_checks++;
    if (dropped_count !== 16'(want_drop)) $display("FAIL steal_drop: %0d, required %0d", dropped_count, want_drop);
    else n_pass++;
    n_checks++;
    if (voice_gate !== 8'hFF) $display("FAIL steal_gate: %h, required ff", voice_gate);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_key(9'h015, 1'b1);
    send_key(9'h04A, 1'b1);
    raw_key(9'h116, 1'b1);
    m_drop++;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_first: %0b, required 1", busy);
    else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_second: %0b, required 1", busy);
    else n_pass++;
    wait_idle("b2b");
    n_checks++;
    if (dropped_count !== 16'(m_drop) || voice_gate !== 8'h03) $display("FAIL b2b_result: drop=%0d gate=%h, required %0d/03", dropped_count, voice_gate, m_drop);
    else n_pass++;
    n_checks++;
    if (voice_key[0] !== 9'h015 || voice_key[1] !== 9'h04A) $display("FAIL b2b_order: key0=%h key1=%h, required 015/04a", voice_key[0], voice_key[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    logic saw_bad;
    send_key(9'h05A, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_gate !== '0 || voice_trig !== '0 || voice_key !== '0 || dropped_count !== 16'd0 || busy !== 1'b0)
      $display("FAIL midscan_reset: gate=%h trig=%h drop=%0d busy=%0b, required all 0", voice_gate, voice_trig, dropped_count, busy);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    saw_bad = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (voice_trig !== '0 || voice_gate !== '0) saw_bad = 1'b1;
    end
    n_checks++;
    if (saw_bad !== 1'b0 || dropped_count !== 16'd0) $display("FAIL midscan_abandon: late output=%0b drop=%0d, required 0/0", saw_bad, dropped_count);
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_key = '0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_press();
    test_two_and_release();
    test_retrigger();
    test_steal();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
